// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, FSM states and saturation constant shared by shift_seq.
package shift_pkg;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_RSV = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    localparam int SHAMT_SAT = 32;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift of acc by 1 or 4 bits; OP_RSV shifts like SRL.
module shift_step import shift_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  op_e               op,
    input  logic              four,
    output logic [DATA_W-1:0] next
);
    logic [2:0] s;
    always_comb begin
        s    = four ? 3'd4 : 3'd1;
        next = op == OP_SLL ? acc << s :
               op == OP_SRA ? DATA_W'($signed(acc) >>> s) : acc >> s;
    end
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle sequential shifter (SLL/SRL/SRA), one bit per cycle.
// Define SHIFT_SEQ_FAST4_EN to take 4-bit steps while at least 4 bits remain.
module shift_seq import shift_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] shamt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d, result_q, result_d, step_acc;
    logic [4:0]        cnt_q, cnt_d;
    logic              four;

`ifdef SHIFT_SEQ_FAST4_EN
    assign four = cnt_q >= 5'd4;
`else
    assign four = 1'b0;
`endif

    shift_step #(.DATA_W(DATA_W)) u_step (
        .acc  (acc_q),
        .op   (op_q),
        .four (four),
        .next (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT;
                op_d    = op_e'(op);
                // Oversized amounts resolve at load time so they cost no shift cycles.
                if (shamt < DATA_W'(SHAMT_SAT)) begin
                    acc_d = operand;
                    cnt_d = shamt[4:0];
                end else begin
                    acc_d = op_e'(op) == OP_SRA ? {DATA_W{operand[DATA_W-1]}} : '0;
                    cnt_d = '0;
                end
            end
            SHIFT: if (cnt_q == 5'd0) begin
                state_d  = DONE;
                result_d = acc_q;
            end else begin
                acc_d = step_acc;
                cnt_d = cnt_q - (four ? 5'd4 : 5'd1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_SLL;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 The block SHALL have one parameter: DATA_W, default 32, operand/result width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a shift; accepted only when busy=0.
REQ-006 The block SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-007 The block SHALL have port operand, input, 32 bits: value to shift.
REQ-008 The block SHALL have port shamt, input, 32 bits: unsigned shift amount, full width.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port result, output, 32 bits: last completed result.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL on the next edge latch op, load acc and cnt, and enter SHIFT.
REQ-014 At the same IDLE-to-SHIFT edge, if shamt<32 the block SHALL load acc=operand and cnt=shamt[4:0].
REQ-015 At the same IDLE-to-SHIFT edge, if shamt>=32 the block SHALL load cnt=0 and acc=0 for SLL/SRL, or acc=32 copies of operand[31] for SRA.
REQ-016 In SHIFT with cnt=0, the block SHALL enter DONE on the next edge.
REQ-017 In SHIFT with cnt≠0, the block SHALL shift acc by one bit per edge and decrement cnt.
REQ-018 SRA shifting SHALL fill vacated bits with acc[31]; SLL and SRL SHALL fill with 0.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle, drive result=acc, and return to IDLE.
REQ-020 result SHALL update only on the edge entering DONE and SHALL hold otherwise.
REQ-021 Without the fast option, done SHALL be high in cycle t+n+2, where start is accepted in cycle t and n is shamt if shamt<32, else 0.
REQ-022 start while busy=1, including in DONE, SHALL be ignored with no queuing.
REQ-023 op=11 SHALL behave as SRL.
REQ-024 Inputs other than start SHALL be sampled only in the accepting cycle; later changes SHALL have no effect.

Reset
REQ-025 rst=1 SHALL force state=IDLE, busy=0, done=0, result=0, acc=0 and cnt=0 on the next edge.
REQ-026 rst mid-operation SHALL abort the shift with no done pulse.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 With macro SHIFT_SEQ_FAST4_EN defined, SHIFT SHALL shift 4 bits and subtract 4 from cnt per edge while cnt>=4, and shift 1 bit otherwise.
REQ-029 With SHIFT_SEQ_FAST4_EN defined, done SHALL be high in cycle t+floor(n/4)+(n mod 4)+2.
REQ-030 Without SHIFT_SEQ_FAST4_EN, only the 1-bit step of REQ-017 SHALL exist; result values SHALL be identical in both builds.

Structure
REQ-031 Package shift_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSV), the FSM state enum, and the constant SHAMT_SAT=32.
REQ-032 Sub-module shift_step SHALL be purely combinational, taking acc, op and a step of 1 or 4 and returning the next acc; it SHALL be the only datapath shifter.

Verification
REQ-033 SRL, operand=0x80000000, shamt=4 -> result=0x08000000; done at t+6, or t+3 with FAST4.
REQ-034 SRA, operand=0x80000000, shamt=31 -> result=0xFFFFFFFF; done at t+33, or t+12 with FAST4.
REQ-035 SLL, operand=0x00000001, shamt=40 -> result=0x00000000 at t+2; SRA, operand=0x80000001, shamt=0xFFFFFFFF -> result=0xFFFFFFFF at t+2.
REQ-036 shamt=0, operand=0x1234ABCD, any op -> result=0x1234ABCD at t+2.
REQ-037 Start SRL 0xF0000000 by 8; pulse start with other data at t+3 -> second start ignored, result=0x00F00000, exactly one done pulse.
REQ-038 Start SLL by 20 with result previously 0x55; assert rst at t+5 -> busy=0 and result=0 next cycle, no done pulse; a new request afterwards completes normally.
